// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the Q1.7 mactop MAC: buffers (A,B) pairs, clears the
// accumulator per frame, streams pairs, and returns the captured result.

// Generic FIFO, count-tracked, registered push_rdy; one write + one read per cycle.
// Latency: push to pop_vld 1 cycle; a pop while full raises push_rdy only on the next cycle.
module op_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          push, pop;

    assign push    = push_vld && push_rdy;
    assign pop     = pop_vld && pop_rdy;
    assign pop_vld = (cnt != '0);
    assign pop_dat = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + (AW+1)'(1);
        else if (pop && !push)
            cnt_nxt = cnt - (AW+1)'(1);
    end

    // push_rdy is computed from the next count so it is a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            push_rdy <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt      <= cnt_nxt;
            push_rdy <= (cnt_nxt != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Frame sequencer: IDLE -> CLEAR -> ISSUE (1 pair/cycle, zero bubbles) -> DRAIN -> HOLD.
// Result valid MAC_LAT+1 cycles after the last pair; held until res_ready, input stalls only on a full FIFO.
module mac_operand_sequencer #(
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    output logic             mac_clr,
    input  logic [7:0]       mac_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [CNT_W-1:0] res_count
);
    localparam int LW = $clog2(MAC_LAT + 1);

    typedef struct packed {
        logic       last;
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, HOLD} state_t;

    pair_t      push_dat, pop_dat;
    logic       pop_vld, pop_rdy;
    state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [LW-1:0]    lat;

    assign push_dat = {in_last, in_a, in_b};
    assign pop_rdy  = (state == ISSUE);

    op_fifo #(.W($bits(pair_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .pop_rdy  (pop_rdy),
        .pop_dat  (pop_dat)
    );

    // Operands and clear default to zero every cycle, so only ISSUE pops reach the MAC.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
            cnt       <= '0;
            lat       <= '0;
        end else begin
            mac_a   <= '0;
            mac_b   <= '0;
            mac_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_vld) begin
                        state   <= CLEAR;
                        mac_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (pop_vld) begin
                        mac_a <= pop_dat.a;
                        mac_b <= pop_dat.b;
                        if (cnt != '1) cnt <= cnt + CNT_W'(1);
                        if (pop_dat.last) begin
                            state <= DRAIN;
                            lat   <= LW'(MAC_LAT);
                        end
                    end
                end
                DRAIN: begin
                    // lat reaches zero in the cycle mac_o first reflects the last pair.
                    if (lat == '0) begin
                        res_data  <= mac_o;
                        res_count <= cnt;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        lat <= lat - LW'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop_vld) begin
                            state   <= CLEAR;
                            mac_clr <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Hardware driver for the mactop 8-bit Q1.7 multiply-accumulate unit. It performs the role the bench plays today, as synthesizable RTL.
- Accepts operand pairs (A, B) through a valid/ready stream and buffers them in a small FIFO.
- Clears the MAC, issues one pair per cycle, and pads with zeros.
- Captures the accumulated result after the pair flagged last, and presents it on a valid/ready result port.
- Sits between the upstream data source and mactop on the Artix-7 design.

Parameters:
DEPTH, 4, operand FIFO depth in pairs (power of 2, ≥2)
MAC_LAT, 1, cycles from a pair on mac_a/mac_b to its effect on mac_o (≥1)
CNT_W, 8, width of the pair counter in a frame

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept a pair
in_a  input  8  operand A, Q1.7 two's complement
in_b  input  8  operand B, Q1.7 two's complement
in_last  input  1  pair is the final pair of a frame (dot product)
mac_a  output  8  operand A to mactop (registered)
mac_b  output  8  operand B to mactop (registered)
mac_clr  output  1  one-cycle accumulator clear to mactop (registered, active high)
mac_o  input  8  mactop accumulator output O
res_valid  output  1  frame result available
res_ready  input  1  consumer accepts result
res_data  output  8  captured accumulator value, Q1.7
res_count  output  CNT_W  number of pairs in the frame, saturating at all-ones

Behaviour:
Reset (async assert, sync release):
- Outputs reset to: in_ready=0 during reset; mac_a=mac_b=0; mac_clr=0; res_valid=0; res_data=0; res_count=0.
- FIFO is emptied, FSM goes to IDLE.
- Reset mid-frame discards all buffered pairs and any partial result.

FIFO:
- Push when in_valid && in_ready. in_ready = !full, registered-equivalent.
- A simultaneous pop while full does not raise in_ready in the same cycle.
- Stores {last, a, b}. Pointers wrap modulo DEPTH.

FSM states:
- IDLE: mac_a=mac_b=0, so the MAC adds 0 each cycle. Goes to CLEAR when the FIFO is non-empty.
- CLEAR: mac_clr=1 for exactly one cycle with operands 0. The pair counter is zeroed. Goes to ISSUE.
- ISSUE:
  - FIFO non-empty: pop one pair and register it onto mac_a/mac_b; the counter increments, saturating.
  - FIFO empty (bubble): drive zeros and stay in ISSUE. A bubble does not change the accumulator.
  - Popped entry has last=1: go to DRAIN, load the latency counter with MAC_LAT.
- DRAIN:
  - Drive zeros and decrement the latency counter.
  - The last pair is on mac_a/mac_b in cycle k. mac_o is sampled at the end of cycle k+MAC_LAT into res_data, together with res_count.
  - res_valid=1 from cycle k+MAC_LAT+1. Go to HOLD.
- HOLD:
  - res_valid stays high; res_data and res_count are stable until res_valid && res_ready.
  - On acceptance, res_valid clears next cycle. Go to CLEAR if the FIFO is non-empty, else IDLE.
  - The FIFO keeps accepting input while in HOLD.

Timing and data rules:
- Throughput is 1 pair/cycle in ISSUE. Per-frame overhead is 1 CLEAR cycle, MAC_LAT drain cycles, and ≥1 handshake cycle.
- mac_clr is never asserted in the same cycle as a non-zero operand.
- Arithmetic, rounding and saturation belong to mactop. This block passes mac_o through unmodified.
- Frame boundary: the pair after in_last starts a new frame and is never issued before the previous result is accepted.

Test Plan:
1. Reset then frame {(0xC0,0xC0),(0xA0,0xA0),(0xC0,0x20,last)} fed back-to-back, res_ready=1 -> mac_clr pulses once, then three consecutive issue cycles; res_data=0x58 (0.25+0.5625−0.125=0.6875), res_count=3, res_valid high 1+MAC_LAT cycles after the last pair is issued.
2. Single-pair frame (0x40,0x40,last) -> res_data=0x20 (0.25), res_count=1; a following frame (0x20,0x20,last) yields 0x08, proving the accumulator was cleared between frames.
3. Bubble: pairs of scenario 1 with 3 idle cycles between the 2nd and 3rd pairs -> zeros on mac_a/mac_b during the gap, same result 0x58, res_count=3.
4. Backpressure: res_ready=0 for 10 cycles with 6 pairs pending, DEPTH=4 -> in_ready drops after 4 buffered pairs; res_data is held stable; after acceptance the FIFO drains and the next frame proceeds without loss.
5. Reset mid-ISSUE after 2 of 3 pairs -> all outputs return to reset values immediately; a subsequent fresh frame (0xC0,0x20,last) gives 0xF0 (−0.125), res_count=1.
6. Counter saturation with CNT_W=2: 5-pair all-zero frame -> res_count=3, res_data=0x00.
